// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one fifo write port between
// NREQ valid/ready producers. A word moves when the owner's req is high and
// the fifo is not full; ownership rotates at burst end or when the owner
// drops its request, with no idle cycle between owners.
//
// Handshake: requester i holds req[i] and its data stable until it sees
// ready[i] high; the word transfers on the rising edge where req[i] and
// ready[i] are both high, and the fifo takes the same word on that edge
// through fifo_wr/fifo_din.
module fifo_write_arbiter #(
   parameter int NREQ      = 4,
   parameter int DWIDTH    = 8,
   parameter int MAX_BURST = 4,
   localparam int IDW      = $clog2(NREQ),
   localparam int BCW      = $clog2(MAX_BURST) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*DWIDTH-1:0]   data,
   output logic [NREQ-1:0]          ready,
   input  logic                     fifo_full,
   output logic                     fifo_wr,
   output logic [DWIDTH-1:0]        fifo_din,
   output logic [IDW-1:0]           owner,
   output logic                     busy
);

   typedef enum logic {ST_IDLE, ST_OWN} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    owner_q, owner_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [BCW-1:0]    burst_q, burst_d;

   logic              any_req;
   logic              xfer;
   logic              burst_end;
   logic              release_own;
   logic [IDW-1:0]    pick_base;
   logic [IDW:0]      shamt;
   logic [2*NREQ-1:0] req_rot;
   logic [IDW-1:0]    rr_pick;

   assign any_req     = |req;
   assign xfer        = (state_q == ST_OWN) & req[owner_q] & ~fifo_full;
   assign burst_end   = (burst_q == BCW'(MAX_BURST - 1));
   assign release_own = ~req[owner_q] | (xfer & burst_end);

   // While owning, search from the owner; from idle, from the last owner served.
   assign pick_base = (state_q == ST_OWN) ? owner_q : last_q;
   assign shamt     = {1'b0, pick_base} + (IDW + 1)'(1);
   // Bit k of req_rot is the request of index (pick_base + 1 + k) mod NREQ,
   // so the base itself lands at bit NREQ-1 and is ranked last.
   assign req_rot   = {req, req} >> shamt;

   // Round-robin pick: lowest set bit of the rotated request vector.
   always_comb begin
      int off;
      off = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) off = k;
      end
      rr_pick = IDW'((int'(pick_base) + 1 + off) % NREQ);
   end

   // Grant decode and write-data mux; nothing leaves the block unless xfer.
   always_comb begin
      ready    = '0;
      fifo_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (xfer && (owner_q == IDW'(i))) begin
            ready[i] = 1'b1;
            fifo_din = data[i*DWIDTH +: DWIDTH];
         end
      end
   end

   assign fifo_wr = xfer;
   assign busy    = (state_q == ST_OWN);
   assign owner   = owner_q;

   // Next-state logic: grant, burst counting, rotation and return to idle.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      burst_d = burst_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_OWN;
               owner_d = rr_pick;
               burst_d = '0;
            end
         end
         ST_OWN: begin
            if (!release_own) begin
               if (xfer) burst_d = burst_q + BCW'(1);
            end else if (any_req) begin
               owner_d = rr_pick;
               burst_d = '0;
            end else begin
               state_d = ST_IDLE;
               last_d  = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset points the search at index 0 first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         burst_q <= '0;
         last_q  <= IDW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer words live in small per-requester
// buffers, expected {owner, word} writes are queued when a scenario is set
// up and popped whenever the DUT strobes fifo_wr.
module tb_fifo_write_arbiter;

   localparam int NREQ      = 4;
   localparam int DWIDTH    = 8;
   localparam int MAX_BURST = 4;
   localparam int IDW       = 2;

   logic                   clk;
   logic                   rst_n;
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] data;
   logic [NREQ-1:0]        ready;
   logic                   fifo_full;
   logic                   fifo_wr;
   logic [DWIDTH-1:0]      fifo_din;
   logic [IDW-1:0]         owner;
   logic                   busy;

   fifo_write_arbiter #(
      .NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ready(ready),
      .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
      .owner(owner), .busy(busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0;

   logic [IDW+DWIDTH-1:0] exp_q[$];
   logic [DWIDTH-1:0]     src_mem[NREQ][64];
   int                    src_rd[NREQ];
   int                    src_wr[NREQ];
   logic [NREQ-1:0]       en;

   logic                  s_wr, s_busy;
   logic [IDW-1:0]        s_owner;
   logic [DWIDTH-1:0]     s_din;
   logic [NREQ-1:0]       s_ready;

   // ---------------- driver tasks ----------------
   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = en[i] && (src_wr[i] > src_rd[i]);
         data[i*DWIDTH +: DWIDTH] = (src_wr[i] > src_rd[i]) ? src_mem[i][src_rd[i]] : '0;
      end
   endtask

   task automatic push_word(input int i, input logic [DWIDTH-1:0] d);
      src_mem[i][src_wr[i]] = d;
      src_wr[i]++;
   endtask

   task automatic expect_wr(input logic [IDW-1:0] o, input logic [DWIDTH-1:0] d);
      exp_q.push_back({o, d});
   endtask

   task automatic clear_src();
      for (int i = 0; i < NREQ; i++) begin
         src_rd[i] = 0;
         src_wr[i] = 0;
      end
      en = '0;
   endtask

   // One cycle: sample at the falling edge, score, then advance producers.
   task automatic step();
      logic [NREQ-1:0]       take;
      logic [NREQ-1:0]       exp_rdy;
      logic [IDW+DWIDTH-1:0] e;
      @(negedge clk);
      s_wr = fifo_wr; s_busy = busy; s_owner = owner; s_din = fifo_din; s_ready = ready;
      take = req & ready;
      exp_rdy = '0;
      if (s_wr === 1'b1) exp_rdy[s_owner] = 1'b1;
      total++;
      if (s_ready !== exp_rdy) begin
         bad++;
         $display("FAIL ready_onehot: got %b want %b", s_ready, exp_rdy);
      end
      if (s_wr === 1'b1) begin
         wr_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got owner=%0d din=%h want no write", s_owner, s_din);
         end else begin
            e = exp_q.pop_front();
            if ({s_owner, s_din} !== e) begin
               bad++;
               $display("FAIL write_data: got owner=%0d din=%h want owner=%0d din=%h",
                        s_owner, s_din, e[IDW+DWIDTH-1:DWIDTH], e[DWIDTH-1:0]);
            end
         end
      end else begin
         total++;
         if (s_din !== '0) begin
            bad++;
            $display("FAIL din_idle: got %h want 00", s_din);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (take[i]) src_rd[i]++;
      apply();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 200) begin
         step();
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL drain_timeout: got %0d writes pending want 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      fifo_full = 1'b0;
      apply();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      fifo_full = 1'b0;
      clear_src();
      for (int i = 0; i < NREQ; i++) begin
         push_word(i, 8'hA0 + 8'(i));
         expect_wr(IDW'(i), 8'hA0 + 8'(i));
      end
      en = '1;
      apply();
      #1;
      total++;
      if (fifo_wr !== 1'b0 || ready !== '0 || fifo_din !== '0 || busy !== 1'b0 || owner !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got wr=%b rdy=%b din=%h busy=%b own=%0d want 0 0 00 0 0",
                  fifo_wr, ready, fifo_din, busy, owner);
      end
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (s_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_cycle: got busy=%b want 0", s_busy);
      end
      step();
      total++;
      if (s_wr !== 1'b1 || s_owner !== 2'd0) begin
         bad++;
         $display("FAIL reset_first_grant: got wr=%b owner=%0d want 1 0", s_wr, s_owner);
      end
      drain();
   endtask

   task automatic test_sole();
      for (int k = 0; k < 6; k++) begin
         push_word(0, 8'h10 + 8'(k));
         expect_wr(2'd0, 8'h10 + 8'(k));
      end
      en = 4'b0001;
      apply();
      step();
      total++;
      if (s_busy !== 1'b0 || s_wr !== 1'b0) begin
         bad++;
         $display("FAIL sole_idle: got busy=%b wr=%b want 0 0", s_busy, s_wr);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         total++;
         if (s_wr !== 1'b1 || s_owner !== 2'd0) begin
            bad++;
            $display("FAIL sole_burst[%0d]: got wr=%b owner=%0d want 1 0", k, s_wr, s_owner);
         end
      end
      drain();
   endtask

   task automatic test_two_rr();
      logic [IDW-1:0] eo;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         push_word(0, 8'h20 + 8'(k));
         push_word(2, 8'h40 + 8'(k));
      end
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 4; k++) expect_wr(2'd0, 8'h20 + 8'(b*4 + k));
         for (int k = 0; k < 4; k++) expect_wr(2'd2, 8'h40 + 8'(b*4 + k));
      end
      en = 4'b0101;
      apply();
      step();
      for (int k = 0; k < 24; k++) begin
         step();
         eo = ((k / 4) % 2 == 0) ? 2'd0 : 2'd2;
         total++;
         if (s_wr !== 1'b1 || s_owner !== eo) begin
            bad++;
            $display("FAIL rr_seq[%0d]: got wr=%b owner=%0d want 1 %0d", k, s_wr, s_owner, eo);
         end
      end
      drain();
   endtask

   task automatic test_full_hold();
      do_reset();
      for (int k = 0; k < 6; k++) push_word(1, 8'h60 + 8'(k));
      push_word(2, 8'h70);
      push_word(2, 8'h71);
      for (int k = 0; k < 4; k++) expect_wr(2'd1, 8'h60 + 8'(k));
      expect_wr(2'd2, 8'h70);
      expect_wr(2'd2, 8'h71);
      expect_wr(2'd1, 8'h64);
      expect_wr(2'd1, 8'h65);
      en = 4'b0110;
      apply();
      step();
      step();
      step();
      fifo_full = 1'b1;
      apply();
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (s_wr !== 1'b0 || s_ready !== '0 || s_owner !== 2'd1 || s_busy !== 1'b1) begin
            bad++;
            $display("FAIL full_block[%0d]: got wr=%b rdy=%b owner=%0d busy=%b want 0 0000 1 1",
                     k, s_wr, s_ready, s_owner, s_busy);
         end
      end
      fifo_full = 1'b0;
      apply();
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (s_wr !== 1'b1 || s_owner !== 2'd1) begin
            bad++;
            $display("FAIL full_resume[%0d]: got wr=%b owner=%0d want 1 1", k, s_wr, s_owner);
         end
      end
      step();
      total++;
      if (s_wr !== 1'b1 || s_owner !== 2'd2) begin
         bad++;
         $display("FAIL full_rotate: got wr=%b owner=%0d want 1 2", s_wr, s_owner);
      end
      drain();
   endtask

   task automatic test_drop();
      do_reset();
      for (int k = 0; k < 4; k++) push_word(0, 8'h80 + 8'(k));
      push_word(1, 8'h90);
      push_word(1, 8'h91);
      expect_wr(2'd0, 8'h80);
      expect_wr(2'd0, 8'h81);
      expect_wr(2'd1, 8'h90);
      expect_wr(2'd1, 8'h91);
      en = 4'b0011;
      apply();
      step();
      step();
      step();
      en = 4'b0010;
      apply();
      step();
      total++;
      if (s_wr !== 1'b0) begin
         bad++;
         $display("FAIL drop_no_write: got wr=%b want 0", s_wr);
      end
      step();
      total++;
      if (s_wr !== 1'b1 || s_owner !== 2'd1 || s_din !== 8'h90) begin
         bad++;
         $display("FAIL drop_handover: got wr=%b owner=%0d din=%h want 1 1 90", s_wr, s_owner, s_din);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 4; k++) push_word(3, 8'hC0 + 8'(k));
      expect_wr(2'd3, 8'hC0);
      en = 4'b1000;
      apply();
      step();
      step();
      total++;
      if (fifo_wr !== 1'b1 || owner !== 2'd3) begin
         bad++;
         $display("FAIL mid_precond: got wr=%b owner=%0d want 1 3", fifo_wr, owner);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (fifo_wr !== 1'b0 || busy !== 1'b0 || ready !== '0 || owner !== '0) begin
         bad++;
         $display("FAIL mid_async_reset: got wr=%b busy=%b rdy=%b owner=%0d want 0 0 0000 0",
                  fifo_wr, busy, ready, owner);
      end
      clear_src();
      push_word(1, 8'hD1);
      push_word(3, 8'hD3);
      expect_wr(2'd1, 8'hD1);
      expect_wr(2'd3, 8'hD3);
      en = 4'b1010;
      apply();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      step();
      total++;
      if (s_wr !== 1'b1 || s_owner !== 2'd1 || s_din !== 8'hD1) begin
         bad++;
         $display("FAIL mid_restart_grant: got wr=%b owner=%0d din=%h want 1 1 d1", s_wr, s_owner, s_din);
      end
      drain();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_sole();
      test_two_rr();
      test_full_hold();
      test_drop();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected: got %0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
